uart_tx_arb: RTL and testbench
==============================

// Module: uart_tx_arb
// PURPOSE
//  Packet-level arbiter sharing the single uart_tx serializer between NUM_REQ
//  byte-stream report formatters (phase report, status, debug dumps).
//  Grants one requester at a time round-robin, forwards its bytes one per
//  uart_tx empty slot, and holds the grant until the byte flagged last.
//  A stalled packet is aborted by a timeout.
// PARAMETERS
//  NUM_REQ      4       number of requesters (2..8)
//  TIMEOUT_CYC  100000  idle cycles in SEND with uart ready and no valid -> abort
// PORTS
//  i_clk            in   1          system clock
//  i_rst_n          in   1          reset, asynchronous, active-low
//  i_req_valid      in   NUM_REQ    requester r has byte on i_req_data[8r+7:8r]
//  i_req_data       in   8*NUM_REQ  packed byte per requester
//  i_req_last       in   NUM_REQ    byte of requester r is last of its packet
//  o_req_ready      out  NUM_REQ    byte of requester r accepted this cycle
//  o_grant          out  NUM_REQ    one-hot current owner; 0 when idle
//  o_tx_data        out  8          byte to uart_tx i_data
//  o_tx_en          out  1          1-cycle write strobe to uart_tx i_txen
//  i_tx_empty       in   1          uart_tx o_txempty
//  o_busy           out  1          packet in progress (state != IDLE)
//  o_timeout        out  1          1-cycle pulse: packet aborted by timeout
// BEHAVIOUR
//  Reset: state IDLE, o_grant=0, o_tx_data=0, o_tx_en=0, o_busy=0,
//   o_timeout=0, last-grant pointer = NUM_REQ-1 (requester 0 wins first),
//   timeout counter 0. Reset mid-packet: abandon packet, no further strobes.
//  States: IDLE -> SEND -> HOLD -> (SEND | IDLE).
//  IDLE: if any i_req_valid, pick first valid index searching upward from
//   pointer+1 (wrap at NUM_REQ); register o_grant; go SEND next cycle.
//   Arbitration latency 1 cycle; grant is never changed mid-packet.
//  SEND: o_req_ready[g] = i_tx_empty & i_req_valid[g] (combinational, only
//   granted bit may be 1). On accept: o_tx_data <= byte, o_tx_en <= 1 for
//   exactly one cycle, store last flag, clear timeout counter, go HOLD.
//  HOLD: one cycle, lets uart_tx drop o_txempty; never strobe in HOLD.
//   Next: if stored last -> IDLE, pointer <= g, o_grant <= 0; else SEND.
//  Strobe rule: o_tx_en only when i_tx_empty was 1 in the accepting cycle;
//   back-to-back strobes impossible (min 2 cycles apart).
//  Timeout: in SEND with i_tx_empty=1 and i_req_valid[g]=0, count++;
//   count reaches TIMEOUT_CYC-1 -> o_timeout pulse, go IDLE, pointer <= g,
//   counter 0. Counter holds while i_tx_empty=0 (uart still shifting).
//  o_tx_data holds last byte between strobes. Valid from non-granted
//   requesters is ignored until they win; requesters must hold valid/data.
//  Simultaneous: release (HOLD->IDLE) and new request -> arbitrate in IDLE
//   next cycle; released requester is lowest priority in that round.
//  Single-byte packet (valid & last on first byte) legal: IDLE->SEND->HOLD->IDLE.
// TESTING
//  Req0 3-byte pkt "AB\n", uart model empty 10 cyc after strobe -> 3 strobes,
//   o_tx_data 0x41,0x42,0x0A, grant=0001 throughout, drops after HOLD of 0x0A.
//  Req0,req2 valid same cycle from reset -> req0 granted first, req2 second;
//   then req0 again vs req1 -> req1 wins (round-robin).
//  Req1 mid-packet drops valid with uart empty -> o_timeout after
//   TIMEOUT_CYC cycles, grant 0, next valid requester served.
//  Assert i_rst_n=0 between byte 2 and 3 of a 5-byte pkt -> all outputs 0
//   immediately, no strobe after release until new request.
//  Hold i_tx_empty=0 long with valid high -> no ready, no strobe, no timeout.
//  Non-granted requester valid during packet -> its o_req_ready stays 0.

Source files
------------

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: packet-level round-robin arbiter in front of one uart_tx serializer.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_req_valid/data/last     per-requester byte stream (data packed 8 bits per requester)
//   o_req_ready               combinational accept strobe, only ever on the granted bit
//   o_grant                   one-hot owner of the serializer, 0 when idle
//   o_tx_data, o_tx_en        byte and 1-cycle write strobe towards uart_tx
//   i_tx_empty                uart_tx can take a byte
//   o_busy                    packet in progress
//   o_timeout                 1-cycle pulse when a stalled packet is aborted
module uart_tx_arb #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_en,
    input  logic                   i_tx_empty,
    output logic                   o_busy,
    output logic                   o_timeout
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [PTR_W-1:0]   r_gidx;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_last;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_tx_data;
    logic               r_tx_en;
    logic               r_busy;
    logic               r_timeout;

    logic               w_any;
    logic [PTR_W-1:0]   w_idx;
    logic               w_gvalid;
    logic [7:0]         w_gdata;
    logic               w_glast;

    // Round-robin pick: scan from farthest to nearest so the requester right after r_ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            int c;
            c = (int'(r_ptr) + k) % int'(NUM_REQ);
            if (i_req_valid[c]) begin
                w_any = 1'b1;
                w_idx = PTR_W'(c);
            end
        end
    end

    // Byte/last/valid of the current owner, selected by the one-hot grant.
    always_comb begin
        w_gdata  = '0;
        w_glast  = 1'b0;
        w_gvalid = |(i_req_valid & r_grant);
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            if (r_grant[r]) begin
                w_gdata = w_gdata | i_req_data[8*r +: 8];
                w_glast = w_glast | i_req_last[r];
            end
        end
    end

    assign o_req_ready = (r_state == ST_SEND && i_tx_empty) ? (i_req_valid & r_grant) : '0;

    // Arbiter FSM; HOLD gives uart_tx one cycle to drop o_txempty after each strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_ptr     <= PTR_W'(NUM_REQ - 1);
            r_last    <= 1'b0;
            r_cnt     <= '0;
            r_tx_data <= '0;
            r_tx_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_tx_en   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= NUM_REQ'(1) << w_idx;
                        r_gidx  <= w_idx;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Nothing moves while uart_tx is still shifting, including the stall counter.
                    if (i_tx_empty) begin
                        if (w_gvalid) begin
                            r_tx_data <= w_gdata;
                            r_tx_en   <= 1'b1;
                            r_last    <= w_glast;
                            r_cnt     <= '0;
                            r_state   <= ST_HOLD;
                        end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                            r_timeout <= 1'b1;
                            r_ptr     <= r_gidx;
                            r_grant   <= '0;
                            r_cnt     <= '0;
                            r_busy    <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_last) begin
                        r_ptr   <= r_gidx;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_SEND;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_grant   = r_grant;
    assign o_tx_data = r_tx_data;
    assign o_tx_en   = r_tx_en;
    assign o_busy    = r_busy;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: randomized packet traffic against a packet-level round-robin model.
module tb_uart_tx_arb;

    localparam int unsigned NR    = 4;
    localparam int unsigned TMO   = 20;
    localparam int unsigned DEPTH = 64;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b1;
    logic [NR-1:0]     i_req_valid = '0;
    logic [8*NR-1:0]   i_req_data = '0;
    logic [NR-1:0]     i_req_last = '0;
    logic [NR-1:0]     o_req_ready;
    logic [NR-1:0]     o_grant;
    logic [7:0]        o_tx_data;
    logic              o_tx_en;
    logic              i_tx_empty = 1'b1;
    logic              o_busy;
    logic              o_timeout;

    uart_tx_arb #(.NUM_REQ(NR), .TIMEOUT_CYC(TMO)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_grant     (o_grant),
        .o_tx_data   (o_tx_data),
        .o_tx_en     (o_tx_en),
        .i_tx_empty  (i_tx_empty),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // Requester byte stores: each requester presents pk_*[r][rd[r]] while rd[r] < wr[r].
    logic [7:0]     pk_data [NR][DEPTH];
    bit             pk_last [NR][DEPTH];
    int             wr [NR];
    int             rd [NR];

    // Expected strobe order from the model, plus the observed grant at each strobe.
    int             e_req [$];
    logic [7:0]     e_byte [$];
    logic [NR-1:0]  s_gnt [$];
    int             e_idx, e_tmo, tmo_seen, m_ptr;

    int             u_delay, ucnt, cyc, last_strobe;
    bit             force_full, prev_tmo;
    int             n_pass, n_total;

    task automatic clear_queues();
        for (int r = 0; r < int'(NR); r++) begin
            wr[r] = 0;
            rd[r] = 0;
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] b, input bit last);
        pk_data[r][wr[r]] = b;
        pk_last[r][wr[r]] = last;
        wr[r]++;
    endtask

    task automatic push_pkt(input int r, input int len, input bit term);
        for (int i = 0; i < len; i++)
            push_byte(r, 8'($urandom_range(0, 255)), term && (i == len - 1));
    endtask

    // Packet-level model: owner = first requester after the last owner with a pending packet;
    // a packet that runs dry before its last byte ends in one timeout.
    task automatic model_build();
        int p [NR];
        bit more;
        int sel;
        bit done;
        for (int r = 0; r < int'(NR); r++) p[r] = rd[r];
        more = 1'b1;
        while (more) begin
            sel = -1;
            for (int k = 1; k <= int'(NR); k++) begin
                int c;
                c = (m_ptr + k) % int'(NR);
                if (sel < 0 && p[c] < wr[c]) sel = c;
            end
            if (sel < 0) begin
                more = 1'b0;
            end else begin
                done = 1'b0;
                while (!done && p[sel] < wr[sel]) begin
                    e_req.push_back(sel);
                    e_byte.push_back(pk_data[sel][p[sel]]);
                    done = pk_last[sel][p[sel]];
                    p[sel]++;
                end
                if (!done) e_tmo++;
                m_ptr = sel;
            end
        end
    endtask

    task automatic drive_inputs();
        for (int r = 0; r < int'(NR); r++) begin
            if (rd[r] < wr[r]) begin
                i_req_valid[r]       = 1'b1;
                i_req_data[8*r +: 8] = pk_data[r][rd[r]];
                i_req_last[r]        = pk_last[r][rd[r]];
            end else begin
                i_req_valid[r]       = 1'b0;
                i_req_data[8*r +: 8] = 8'h00;
                i_req_last[r]        = 1'b0;
            end
        end
        i_tx_empty = !force_full && (ucnt == 0);
    endtask

    // One clock: drive requesters and uart model, monitor the cycle's accept/strobe/timeout.
    task automatic cycle_step();
        logic [NR-1:0] rdy_s, gnt_s, exp_g;
        drive_inputs();
        @(negedge i_clk);
        rdy_s = o_req_ready;
        gnt_s = o_grant;
        n_total++;
        if ((rdy_s & ~gnt_s) !== '0)
            $display("FAIL ready_outside_grant cyc=%0d ready=%b grant=%b required ready within grant", cyc, rdy_s, gnt_s);
        else n_pass++;
        @(posedge i_clk);
        #1;
        cyc++;
        for (int r = 0; r < int'(NR); r++) if (rdy_s[r]) rd[r]++;
        n_total++;
        if (o_tx_en !== (rdy_s != '0))
            $display("FAIL strobe_vs_accept cyc=%0d tx_en=%b ready_before=%b required tx_en=%b", cyc, o_tx_en, rdy_s, (rdy_s != '0));
        else n_pass++;
        if (o_tx_en === 1'b1) begin
            n_total++;
            if (cyc - last_strobe < 2)
                $display("FAIL strobe_gap cyc=%0d gap=%0d required >=2", cyc, cyc - last_strobe);
            else n_pass++;
            if (e_idx < e_req.size()) begin
                exp_g = '0;
                exp_g[e_req[e_idx]] = 1'b1;
                n_total++;
                if (o_tx_data !== e_byte[e_idx])
                    $display("FAIL tx_data strobe#%0d got=%h required=%h", e_idx, o_tx_data, e_byte[e_idx]);
                else n_pass++;
                n_total++;
                if (o_grant !== exp_g)
                    $display("FAIL strobe_grant strobe#%0d got=%b required=%b", e_idx, o_grant, exp_g);
                else n_pass++;
            end else begin
                n_total++;
                $display("FAIL unexpected_strobe cyc=%0d data=%h grant=%b required no strobe", cyc, o_tx_data, o_grant);
            end
            s_gnt.push_back(o_grant);
            e_idx++;
            last_strobe = cyc;
            ucnt = u_delay;
        end else if (ucnt > 0) begin
            ucnt--;
        end
        if (o_timeout === 1'b1) begin
            tmo_seen++;
            n_total++;
            if (tmo_seen > e_tmo || prev_tmo)
                $display("FAIL unexpected_timeout cyc=%0d seen=%0d required<=%0d", cyc, tmo_seen, e_tmo);
            else n_pass++;
            n_total++;
            if (o_grant !== '0)
                $display("FAIL timeout_grant got=%b required=0", o_grant);
            else n_pass++;
            if (u_delay == 0) begin
                n_total++;
                if (cyc - last_strobe != int'(TMO) + 1)
                    $display("FAIL timeout_latency got=%0d required=%0d", cyc - last_strobe, TMO + 1);
                else n_pass++;
            end
        end
        prev_tmo = (o_timeout === 1'b1);
    endtask

    task automatic run_phase(input int delay, input int budget);
        int n;
        bit drained;
        u_delay = delay;
        n = 0;
        drained = 1'b0;
        while (!drained && n < budget) begin
            cycle_step();
            n++;
            drained = (e_idx >= e_req.size()) && (tmo_seen >= e_tmo) && (o_busy === 1'b0);
            for (int r = 0; r < int'(NR); r++) if (rd[r] < wr[r]) drained = 1'b0;
        end
        n_total++;
        if (!drained)
            $display("FAIL phase_budget strobes=%0d required=%0d timeouts=%0d required=%0d", e_idx, e_req.size(), tmo_seen, e_tmo);
        else n_pass++;
        n_total++;
        if (o_grant !== '0 || o_busy !== 1'b0)
            $display("FAIL idle_after_phase grant=%b busy=%b required 0/0", o_grant, o_busy);
        else n_pass++;
    endtask

    task automatic clear_model();
        e_req.delete();
        e_byte.delete();
        s_gnt.delete();
        e_idx = 0;
        e_tmo = 0;
        tmo_seen = 0;
        m_ptr = int'(NR) - 1;
        ucnt = 0;
        force_full = 1'b0;
        prev_tmo = 1'b0;
        last_strobe = -100;
    endtask

    task automatic check_all_zero(input string tag);
        n_total++;
        if (o_grant !== '0 || o_tx_en !== 1'b0 || o_tx_data !== 8'h00 || o_busy !== 1'b0 ||
            o_timeout !== 1'b0 || o_req_ready !== '0)
            $display("FAIL %s grant=%b tx_en=%b tx_data=%h busy=%b timeout=%b ready=%b required all 0",
                     tag, o_grant, o_tx_en, o_tx_data, o_busy, o_timeout, o_req_ready);
        else n_pass++;
    endtask

    task automatic do_reset();
        clear_queues();
        clear_model();
        drive_inputs();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_queues();
        clear_model();
        drive_inputs();
        #2;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("reset_state");
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) cycle_step();
        check_all_zero("idle_no_request");
    endtask

    task automatic test_abn();
        do_reset();
        push_byte(0, 8'h41, 1'b0);
        push_byte(0, 8'h42, 1'b0);
        push_byte(0, 8'h0A, 1'b1);
        model_build();
        run_phase(10, 200);
        n_total++;
        if (s_gnt.size() != 3 || s_gnt[0] !== 4'b0001 || s_gnt[2] !== 4'b0001)
            $display("FAIL abn_strobes count=%0d required=3 with grant 0001", s_gnt.size());
        else n_pass++;
        n_total++;
        if (o_tx_data !== 8'h0A)
            $display("FAIL abn_data_hold got=%h required=0a", o_tx_data);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        push_pkt(0, 2, 1'b1);
        push_pkt(2, 2, 1'b1);
        model_build();
        run_phase(4, 300);
        n_total++;
        if (s_gnt.size() != 4 || s_gnt[0] !== 4'b0001 || s_gnt[3] !== 4'b0100)
            $display("FAIL rr_first_round size=%0d first=%b last=%b required 0001 then 0100",
                     s_gnt.size(), s_gnt.size() > 0 ? s_gnt[0] : 4'b0, s_gnt.size() > 3 ? s_gnt[3] : 4'b0);
        else n_pass++;
        clear_queues();
        s_gnt.delete(); e_req.delete(); e_byte.delete(); e_idx = 0;
        push_pkt(0, 1, 1'b1);
        model_build();
        run_phase(2, 100);
        clear_queues();
        s_gnt.delete(); e_req.delete(); e_byte.delete(); e_idx = 0;
        push_pkt(0, 2, 1'b1);
        push_pkt(1, 2, 1'b1);
        model_build();
        run_phase(2, 200);
        n_total++;
        if (s_gnt.size() != 4 || s_gnt[0] !== 4'b0010 || s_gnt[2] !== 4'b0001)
            $display("FAIL rr_req1_wins size=%0d first=%b required 0010 then 0001",
                     s_gnt.size(), s_gnt.size() > 0 ? s_gnt[0] : 4'b0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        push_pkt(1, 2, 1'b0);
        push_pkt(3, 2, 1'b1);
        model_build();
        run_phase(0, 300);
        n_total++;
        if (tmo_seen != 1)
            $display("FAIL timeout_count got=%0d required=1", tmo_seen);
        else n_pass++;
        n_total++;
        if (s_gnt.size() != 4 || s_gnt[1] !== 4'b0010 || s_gnt[2] !== 4'b1000)
            $display("FAIL timeout_next_owner size=%0d required 0010,0010,1000,1000", s_gnt.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        push_pkt(0, 5, 1'b1);
        model_build();
        u_delay = 10;
        n = 0;
        while (e_idx < 2 && n < 100) begin
            cycle_step();
            n++;
        end
        repeat (3) cycle_step();
        #2;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_packet");
        clear_queues();
        clear_model();
        drive_inputs();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (30) cycle_step();
        n_total++;
        if (e_idx != 0 || o_busy !== 1'b0)
            $display("FAIL post_reset_quiet strobes=%0d busy=%b required 0/0", e_idx, o_busy);
        else n_pass++;
    endtask

    task automatic test_tx_full();
        do_reset();
        push_pkt(2, 1, 1'b1);
        model_build();
        force_full = 1'b1;
        u_delay = 3;
        repeat (5 * TMO) cycle_step();
        n_total++;
        if (e_idx != 0 || tmo_seen != 0)
            $display("FAIL tx_full_stall strobes=%0d timeouts=%0d required 0/0", e_idx, tmo_seen);
        else n_pass++;
        n_total++;
        if (o_busy !== 1'b1 || o_grant !== 4'b0100)
            $display("FAIL tx_full_grant busy=%b grant=%b required 1/0100", o_busy, o_grant);
        else n_pass++;
        force_full = 1'b0;
        run_phase(3, 100);
    endtask

    task automatic test_nongranted();
        int n;
        do_reset();
        push_pkt(0, 4, 1'b1);
        push_pkt(1, 1, 1'b1);
        model_build();
        u_delay = 5;
        n = 0;
        while (e_idx < 4 && n < 200) begin
            cycle_step();
            n++;
        end
        n_total++;
        if (rd[1] != 0)
            $display("FAIL nongranted_accept popped=%0d required=0", rd[1]);
        else n_pass++;
        run_phase(5, 100);
        n_total++;
        if (rd[1] != 1)
            $display("FAIL nongranted_served popped=%0d required=1", rd[1]);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int ph = 0; ph < 6; ph++) begin
            clear_queues();
            s_gnt.delete();
            for (int r = 0; r < int'(NR); r++) begin
                int npk;
                npk = int'($urandom_range(0, 2));
                for (int p = 0; p < npk; p++) push_pkt(r, int'($urandom_range(1, 5)), 1'b1);
            end
            model_build();
            run_phase(int'($urandom_range(0, 12)), 3000);
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        cyc = 0;
        u_delay = 0;
        clear_queues();
        clear_model();
        test_reset();
        test_abn();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_tx_full();
        test_nongranted();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
